// File: rtl/axi_keypad_scanner.sv
// Matrix keypad scanner with frame-based debounce, a key-event FIFO and an AXI4-Lite register window.
// Columns are strobed one at a time. Each accepted key change produces at most one FIFO event.
module axi_keypad_scanner #(
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic            ACLK,
   input  logic            ARESETN,
   input  logic [3:0]      S_AXI_AWADDR,
   input  logic            S_AXI_AWVALID,
   output logic            S_AXI_AWREADY,
   input  logic [31:0]     S_AXI_WDATA,
   input  logic [3:0]      S_AXI_WSTRB,
   input  logic            S_AXI_WVALID,
   output logic            S_AXI_WREADY,
   output logic [1:0]      S_AXI_BRESP,
   output logic            S_AXI_BVALID,
   input  logic            S_AXI_BREADY,
   input  logic [3:0]      S_AXI_ARADDR,
   input  logic            S_AXI_ARVALID,
   output logic            S_AXI_ARREADY,
   output logic [31:0]     S_AXI_RDATA,
   output logic [1:0]      S_AXI_RRESP,
   output logic            S_AXI_RVALID,
   input  logic            S_AXI_RREADY,
   output logic [COLS-1:0] col_n,
   input  logic [ROWS-1:0] row_n,
   output logic            irq
);

   localparam int NKEYS = ROWS * COLS;
   localparam int KEY_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int STB_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;

   localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_FRAMES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);

   localparam logic [3:0] ADDR_CTRL   = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h4;
   localparam logic [3:0] ADDR_DATA   = 4'h8;
   localparam logic [3:0] ADDR_KEYS   = 4'hC;

   typedef struct packed {
      logic       press;
      logic [7:0] idx;
   } key_event_t;

   logic [ROWS-1:0]  row_meta;
   logic [ROWS-1:0]  row_sync;

   logic             ctrl_en;
   logic             ctrl_irq_en;
   logic             ctrl_rel_en;
   logic             ovf;
   logic             irq_q;

   logic [COL_W-1:0] col_idx;
   logic [DIV_W-1:0] div_cnt;
   logic             dwell_end;
   logic             frame_end;
   logic [NKEYS-1:0] raw_acc;
   logic [NKEYS-1:0] frame_now;
   logic [NKEYS-1:0] prev_frame;
   logic [NKEYS-1:0] keys;
   logic [NKEYS-1:0] key_diff;
   logic [NKEYS-1:0] evt_mask;
   logic [STB_W-1:0] stable_cnt;
   logic [STB_W-1:0] stable_next;
   logic [KEY_W-1:0] evt_idx;
   logic             evt_press;
   logic             accept;
   logic             push;

   key_event_t       fifo_mem [FIFO_DEPTH];
   key_event_t       new_evt;
   key_event_t       head;
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic [PTR_W:0]   level;
   logic             empty;
   logic             full;
   logic             pop;
   logic             do_push;
   logic             drop;

   logic             awready_q;
   logic             wready_q;
   logic             bvalid_q;
   logic             arready_q;
   logic             rvalid_q;
   logic [31:0]      rdata_q;
   logic [31:0]      rd_mux;
   logic             wr_hs;
   logic             ar_hs;
   logic             unused_bits;

   assign unused_bits = ^{S_AXI_WDATA[31:3], S_AXI_WSTRB[3:1]};

   // row_n is asynchronous; only row_sync is ever looked at.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         row_meta <= '1;
         row_sync <= '1;
      end else begin
         // NOTE: non-blocking so each flop captures the pre-edge value and the two stages stay distinct.
         row_meta <= row_n;
         row_sync <= row_meta;
      end
   end

   assign dwell_end = (div_cnt == DIV_LAST);
   assign frame_end = dwell_end && (col_idx == COL_LAST);
   assign col_n     = ctrl_en ? ~(COLS'(1) << col_idx) : '1;

   // Current frame with the active column's rows merged in; rows are active-low.
   always_comb begin
      // NOTE: default assignment first so every path drives the signal and no latch is inferred.
      frame_now = raw_acc;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (col_idx == COL_W'(c)) frame_now[r*COLS + c] = ~row_sync[r];
         end
      end
   end

   always_comb begin
      stable_next = '0;
      if (frame_now == prev_frame)
         stable_next = (stable_cnt >= STB_MAX) ? stable_cnt : stable_cnt + 1'b1;
   end

   assign key_diff = frame_now ^ keys;

   // Descending walk so the lowest differing index is the one that sticks.
   always_comb begin
      evt_idx   = '0;
      evt_mask  = '0;
      evt_press = 1'b0;
      for (int i = NKEYS - 1; i >= 0; i--) begin
         if (key_diff[i]) begin
            evt_idx     = KEY_W'(i);
            evt_mask    = '0;
            evt_mask[i] = 1'b1;
            evt_press   = frame_now[i];
         end
      end
   end

   assign accept  = ctrl_en && frame_end && (stable_next >= STB_MAX) && (key_diff != '0);
   assign push    = accept && (evt_press || ctrl_rel_en);
   assign new_evt = '{press: evt_press, idx: 8'(evt_idx)};

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         col_idx    <= '0;
         div_cnt    <= '0;
         raw_acc    <= '0;
         prev_frame <= '0;
         stable_cnt <= '0;
         keys       <= '0;
      end else if (!ctrl_en) begin
         col_idx    <= '0;
         div_cnt    <= '0;
         raw_acc    <= '0;
         prev_frame <= '0;
         stable_cnt <= '0;
         keys       <= '0;
      end else if (dwell_end) begin
         div_cnt <= '0;
         raw_acc <= frame_now;
         col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
         if (frame_end) begin
            prev_frame <= frame_now;
            stable_cnt <= stable_next;
            if (accept) keys <= keys ^ evt_mask;
         end
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign level   = wr_ptr - rd_ptr;
   assign empty   = (level == '0);
   assign full    = (level == FULL_LVL);
   assign ar_hs   = arready_q && S_AXI_ARVALID;
   assign pop     = ar_hs && (S_AXI_ARADDR == ADDR_DATA) && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push && (!full || pop);
   assign drop    = push && full && !pop;
   assign head    = fifo_mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge ACLK) begin
      if (do_push) fifo_mem[wr_ptr[PTR_W-1:0]] <= new_evt;
   end

   always_comb begin
      rd_mux = '0;
      case (S_AXI_ARADDR)
         ADDR_CTRL:   rd_mux = {29'd0, ctrl_rel_en, ctrl_irq_en, ctrl_en};
         ADDR_STATUS: rd_mux = {16'd0, 8'(level), 5'd0, ovf, full, empty};
         ADDR_DATA:   if (!empty) rd_mux = {1'b1, 22'd0, head};
         ADDR_KEYS:   rd_mux = 32'(keys);
         default:     rd_mux = '0;
      endcase
   end

   assign wr_hs = awready_q && wready_q && S_AXI_AWVALID && S_AXI_WVALID;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         ctrl_en     <= 1'b0;
         ctrl_irq_en <= 1'b0;
         ctrl_rel_en <= 1'b0;
         ovf         <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
         wready_q  <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;

         if (wr_hs)             bvalid_q <= 1'b1;
         else if (S_AXI_BREADY) bvalid_q <= 1'b0;

         if (wr_hs && (S_AXI_AWADDR == ADDR_CTRL) && S_AXI_WSTRB[0]) begin
            ctrl_en     <= S_AXI_WDATA[0];
            ctrl_irq_en <= S_AXI_WDATA[1];
            ctrl_rel_en <= S_AXI_WDATA[2];
         end

         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)
            ovf <= 1'b1;
         else if (wr_hs && (S_AXI_AWADDR == ADDR_STATUS) && S_AXI_WSTRB[0] && S_AXI_WDATA[2])
            ovf <= 1'b0;

         arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;

         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
         end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end

         irq_q <= ctrl_irq_en && !empty;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RVALID  = rvalid_q;
   assign irq           = irq_q;

endmodule

// File: tb/tb_axi_keypad_scanner.sv
// Scoreboard bench for axi_keypad_scanner: reads queue their expected data and a monitor compares each R beat.
// A small keypad model drives row_n from the pressed-key map and the DUT's column strobes.
module tb_axi_keypad_scanner;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int FRAME = COLS * 4;
   localparam int TMO   = 400;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [3:0]  awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [3:0]  col_n;
   logic [3:0]  row_n;
   logic        irq;

   logic [15:0] pressed;
   logic [3:0]  glitch;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic [31:0] mon_exp;
   string       mon_name;

   always #5 aclk = ~aclk;

   axi_keypad_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .FIFO_DEPTH(4)
   ) dut (
      .ACLK(aclk), .ARESETN(aresetn),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .col_n(col_n), .row_n(row_n), .irq(irq)
   );

   // A pressed key pulls its row low while its column is strobed; glitch forces a row low outright.
   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         row_n[r] = ~glitch[r];
         for (int c = 0; c < COLS; c++) begin
            if (pressed[r*COLS + c] && !col_n[c]) row_n[r] = 1'b0;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
      end
   endtask

   task automatic timeout_fail(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: no response within %0d cycles", nm, TMO);
   endtask

   always @(negedge aclk) begin
      if (aresetn && rvalid && rready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_read: got 0x%08h with no expectation queued", rdata);
         end else begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            check(mon_name, rdata, mon_exp);
            check({mon_name, "_rresp"}, 32'(rresp), 32'h0);
         end
      end
      if (aresetn && bvalid && bready) check("bresp", 32'(bresp), 32'h0);
   end

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      @(negedge aclk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!awready && n < TMO);
      if (!awready) begin
         timeout_fail("aw_handshake");
         awvalid = 1'b0; wvalid = 1'b0;
         return;
      end
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge aclk);
      check("bvalid_next_cycle", 32'(bvalid), 32'h1);
      @(posedge aclk); #1;
   endtask

   task automatic ar_issue(input logic [3:0] a, output bit ok);
      int n;
      @(negedge aclk);
      araddr = a; arvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!arready && n < TMO);
      ok = arready;
      if (ok) begin @(posedge aclk); #1; end
      arvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] a, input logic [31:0] e, input string nm);
      bit ok;
      int n;
      exp_q.push_back(e);
      name_q.push_back(nm);
      ar_issue(a, ok);
      if (!ok) begin
         timeout_fail({nm, "_ar"});
         void'(exp_q.pop_back());
         void'(name_q.pop_back());
         return;
      end
      n = 0;
      do begin @(negedge aclk); n++; end while (!(rvalid && rready) && n < TMO);
      if (!(rvalid && rready)) begin
         timeout_fail({nm, "_r"});
         void'(exp_q.pop_back());
         void'(name_q.pop_back());
         return;
      end
      @(posedge aclk); #1;
   endtask

   task automatic wait_irq(input string nm);
      int n;
      n = 0;
      do begin @(negedge aclk); n++; end while (!irq && n < TMO);
      check(nm, 32'(irq), 32'h1);
   endtask

   task automatic wait_frames(input int f);
      repeat (f * FRAME) @(negedge aclk);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;
      aresetn = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
      araddr = '0; arvalid = 1'b0; rready = 1'b1;
      pressed = '0; glitch = '0;

      repeat (3) @(negedge aclk);
      check("rst_col_n", 32'(col_n), 32'hF);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);
      aresetn = 1'b1;

      axi_read(4'h4, 32'h0000_0001, "status_after_reset");
      axi_read(4'h0, 32'h0000_0000, "ctrl_after_reset");
      axi_read(4'hC, 32'h0000_0000, "keys_after_reset");

      // Row 1 / column 2 held: key index 6.
      pressed[6] = 1'b1;
      axi_write(4'h0, 32'h3, 4'hF);
      @(negedge aclk);
      check("col_one_low", 32'($countones(~col_n)), 32'h1);
      wait_irq("irq_on_press");
      axi_read(4'h8, 32'h8000_0106, "data_press_6");
      axi_read(4'h4, 32'h0000_0001, "status_after_pop");
      @(negedge aclk);
      check("irq_after_pop", 32'(irq), 32'h0);
      axi_read(4'hC, 32'h0000_0040, "keys_held_6");
      pressed = '0;
      wait_frames(4);
      axi_read(4'hC, 32'h0000_0000, "keys_released");
      axi_read(4'h4, 32'h0000_0001, "status_release_not_queued");

      // One frame of noise on row 0 must not be accepted.
      glitch[0] = 1'b1;
      repeat (FRAME) @(negedge aclk);
      glitch[0] = 1'b0;
      wait_frames(4);
      axi_read(4'hC, 32'h0000_0000, "keys_after_glitch");
      axi_read(4'h4, 32'h0000_0001, "status_after_glitch");

      // Six events into a four-deep FIFO.
      axi_write(4'h0, 32'h7, 4'hF);
      for (int k = 0; k < 3; k++) begin
         pressed[9] = 1'b1;
         wait_frames(4);
         pressed[9] = 1'b0;
         wait_frames(4);
      end
      axi_read(4'h4, 32'h0000_0406, "status_overflow");
      @(negedge aclk);
      check("irq_fifo_full", 32'(irq), 32'h1);
      axi_write(4'h4, 32'h4, 4'hF);
      axi_read(4'h4, 32'h0000_0402, "status_ovf_cleared");
      axi_write(4'h0, 32'h0, 4'h0);
      axi_read(4'h0, 32'h0000_0007, "ctrl_strobe_masked");
      axi_write(4'hC, 32'hFFFF_FFFF, 4'hF);
      axi_read(4'hC, 32'h0000_0000, "keys_write_ignored");
      axi_read(4'h2, 32'h0000_0000, "unmapped_read");
      axi_read(4'h8, 32'h8000_0109, "data_evt0");
      axi_read(4'h8, 32'h8000_0009, "data_evt1");
      axi_read(4'h8, 32'h8000_0109, "data_evt2");
      axi_read(4'h8, 32'h8000_0009, "data_evt3");
      axi_read(4'h4, 32'h0000_0001, "status_drained");
      axi_read(4'h8, 32'h0000_0000, "data_when_empty");
      axi_read(4'h4, 32'h0000_0001, "status_level_zero");

      // Disabling the scanner clears KEYS but keeps queued events.
      axi_write(4'h0, 32'h3, 4'hF);
      pressed[0] = 1'b1;
      wait_irq("irq_on_key0");
      axi_write(4'h0, 32'h0, 4'hF);
      @(negedge aclk);
      check("col_n_disabled", 32'(col_n), 32'hF);
      axi_read(4'hC, 32'h0000_0000, "keys_cleared_by_disable");
      axi_read(4'h4, 32'h0000_0100, "fifo_retained");
      @(negedge aclk);
      check("irq_masked", 32'(irq), 32'h0);

      // Reset with a read response still outstanding.
      axi_write(4'h0, 32'h1, 4'hF);
      wait_frames(4);
      axi_read(4'h4, 32'h0000_0200, "status_two_events");
      rready = 1'b0;
      ar_issue(4'h8, ok);
      if (!ok) timeout_fail("pending_ar");
      n = 0;
      do begin @(negedge aclk); n++; end while (!rvalid && n < TMO);
      repeat (2) @(negedge aclk);
      check("rvalid_held", 32'(rvalid), 32'h1);
      aresetn = 1'b0;
      #1;
      check("rvalid_reset", 32'(rvalid), 32'h0);
      check("col_n_reset", 32'(col_n), 32'hF);
      check("irq_reset", 32'(irq), 32'h0);
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      rready  = 1'b1;
      axi_read(4'h4, 32'h0000_0001, "status_after_abort");
      axi_read(4'hC, 32'h0000_0000, "keys_after_abort");
      axi_read(4'h0, 32'h0000_0000, "ctrl_after_abort");
      pressed = '0;

      repeat (5) @(negedge aclk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_keypad_scanner.md
AXI_KEYPAD_SCANNER -- requirements
Module: axi_keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning the number of keypad rows (1..8).
REQ-002 SHALL have parameter COLS, default 4, meaning the number of keypad columns (1..8); ROWS*COLS SHALL be at most 32.
REQ-003 SHALL have parameter SCAN_DIV, default 1000, meaning ACLK cycles per column dwell (minimum 4).
REQ-004 SHALL have parameter DEBOUNCE_FRAMES, default 4, meaning consecutive identical frames required before a change is accepted (minimum 1).
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning event FIFO entries (power of 2, 2..256).
REQ-006 SHALL have port ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have AW channel ports S_AXI_AWADDR (in, 4), S_AXI_AWVALID (in, 1) and S_AXI_AWREADY (out, 1).
REQ-009 SHALL have W channel ports S_AXI_WDATA (in, 32), S_AXI_WSTRB (in, 4), S_AXI_WVALID (in, 1) and S_AXI_WREADY (out, 1).
REQ-010 SHALL have B channel ports S_AXI_BRESP (out, 2, always 2'b00), S_AXI_BVALID (out, 1) and S_AXI_BREADY (in, 1).
REQ-011 SHALL have AR channel ports S_AXI_ARADDR (in, 4), S_AXI_ARVALID (in, 1) and S_AXI_ARREADY (out, 1).
REQ-012 SHALL have R channel ports S_AXI_RDATA (out, 32), S_AXI_RRESP (out, 2, always 2'b00), S_AXI_RVALID (out, 1) and S_AXI_RREADY (in, 1).
REQ-013 SHALL have port col_n, output, COLS bits: active-low column drive, at most one bit low at a time.
REQ-014 SHALL have port row_n, input, ROWS bits: active-low row sense, asynchronous to ACLK.
REQ-015 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-016 SHALL synchronise row_n through a 2-flop synchroniser before any use.
REQ-017 Register map SHALL be: 0x0 CTRL (RW: bit0 EN, bit1 IRQ_EN, bit2 REL_EN); 0x4 STATUS (bit0 EMPTY, bit1 FULL, bit2 OVF write-1-to-clear, [15:8] level); 0x8 DATA (RO, pops); 0xC KEYS (RO, debounced matrix, bit index = row*COLS+col).
REQ-018 Writes SHALL complete only when AWVALID and WVALID are both high and BVALID is low; AWREADY and WREADY SHALL pulse together for 1 cycle; BVALID SHALL rise the next cycle and hold until BREADY.
REQ-019 Byte lanes with WSTRB=0 SHALL not be modified; writes to 0x8, 0xC and unmapped offsets SHALL be ignored but still return OKAY.
REQ-020 ARREADY SHALL pulse for 1 cycle when ARVALID is high and RVALID is low; RVALID and RDATA SHALL be registered the next cycle and held until RREADY; unmapped reads SHALL return 0.
REQ-021 A DATA read SHALL return {VALID=1, 22'b0, PRESS, idx[7:0]} and pop on the AR handshake; a DATA read when empty SHALL return 0 with no pop.
REQ-022 Scanner: with EN=1, col_n SHALL drive column c low for SCAN_DIV cycles, c=0..COLS-1 then wrap; rows SHALL be sampled on the last dwell cycle; one frame = COLS dwells.
REQ-023 Debounce: when a frame's raw matrix equals the previous frame, a stable counter SHALL increment (saturating); otherwise it SHALL reset to 0.
REQ-024 When the stable counter is at least DEBOUNCE_FRAMES-1 and raw differs from KEYS, at end of frame only the lowest-index differing bit SHALL be updated in KEYS and one event generated; remaining differences resolve in later frames.
REQ-025 Press events SHALL always be pushed; release events (PRESS=0) SHALL be pushed only if REL_EN=1; KEYS SHALL update regardless.
REQ-026 A push when FIFO is full SHALL drop the event and set OVF; OVF SHALL be sticky until written 1.
REQ-027 A simultaneous push and pop when full SHALL succeed with level unchanged; when empty, the pop SHALL return 0 and the push SHALL land.
REQ-028 EN=0 SHALL force col_n to all-1, clear the scan and stable counters and KEYS, and generate no events; FIFO contents SHALL be retained.
REQ-029 irq SHALL equal IRQ_EN AND NOT EMPTY, registered.

Reset
REQ-030 ARESETN low SHALL immediately clear CTRL, OVF, FIFO pointers, KEYS and counters; col_n SHALL be all-1, and irq, AWREADY, WREADY, BVALID, ARREADY and RVALID SHALL be 0.
REQ-031 Reset mid-transaction SHALL abort it and discard any pending response.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_FRAMES=2, FIFO_DEPTH=4)
- Reset release -> STATUS reads 0x00000001, CTRL 0x0, col_n=4'hF, irq=0.
- CTRL=0x3, hold row_n[1] low while col_n[2] is low -> after 2 stable frames irq=1, DATA=0x80000106, then STATUS=0x00000001, irq=0.
- Glitch row_n[0] for 1 frame only -> no event, KEYS=0.
- CTRL=0x7, 3 press/release cycles (6 events) -> STATUS=0x00000406, first 4 events retained in order; write STATUS=0x4 -> OVF clears.
- Read DATA while empty -> 0x00000000, level stays 0.
- Assert ARESETN mid-press with RVALID pending -> RVALID=0, FIFO empty, KEYS=0.
